// File: rtl/mips_ram.sv
// rtl/mips_ram.sv - byte-addressed MIPS data memory with sized stores and sign/zero-extended loads
// Define MIPS_RAM_BIG_ENDIAN_EN for big-endian byte order (little-endian otherwise).
module mips_ram #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        MemWrite,
  input  logic        Byte,
  input  logic        Half,
  input  logic        UnsignedExt_Mem,
  output logic [31:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0]            mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] real_addr;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic                  is_word;
  logic [7:0]            wb0, wb1, wb2, wb3;
  logic [7:0]            rb0, rb1, rb2, rb3;
  logic [31:0]           word_val;
  logic [15:0]           half_val;
  logic                  unused_hi;

  assign real_addr = addr[ADDR_WIDTH-1:0];
  assign unused_hi = ^addr[31:ADDR_WIDTH];
  assign is_word   = !Byte && !Half;

  // Misaligned accesses silently round down to the natural boundary.
  always_comb begin
    a0 = real_addr;
    if (!Byte) a0[0] = 1'b0;
    if (is_word) a0[1] = 1'b0;
  end

  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  assign rb0 = mem[a0];
  assign rb1 = mem[a1];
  assign rb2 = mem[a2];
  assign rb3 = mem[a3];

`ifdef MIPS_RAM_BIG_ENDIAN_EN
  always_comb begin
    {wb0, wb1, wb2, wb3} = data_in;
    if (Byte) begin
      wb0 = data_in[7:0];
    end else if (Half) begin
      {wb0, wb1} = data_in[15:0];
    end
  end

  assign word_val = {rb0, rb1, rb2, rb3};
  assign half_val = {rb0, rb1};
`else
  assign {wb3, wb2, wb1, wb0} = data_in;
  assign word_val = {rb3, rb2, rb1, rb0};
  assign half_val = {rb1, rb0};
`endif

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (MemWrite) begin
      mem[a0] <= wb0;
      if (!Byte) begin
        mem[a1] <= wb1;
      end
      if (is_word) begin
        mem[a2] <= wb2;
        mem[a3] <= wb3;
      end
    end
  end

  // Gating on CLR makes the cleared view visible in the same instant CLR rises.
  always_comb begin
    data_out = 32'h0;
    if (CLR) begin
      data_out = 32'h0;
    end else if (is_word) begin
      data_out = word_val;
    end else if (Byte) begin
      data_out = {{24{rb0[7] & !UnsignedExt_Mem}}, rb0};
    end else begin
      data_out = {{16{half_val[15] & !UnsignedExt_Mem}}, half_val};
    end
  end

endmodule

// File: tb/tb_mips_ram.sv
// tb/tb_mips_ram.sv - randomized self-checking bench for mips_ram against a byte-map model
module tb_mips_ram;

  localparam int          AW    = 20;
  localparam logic [31:0] AMASK = (32'h1 << AW) - 32'h1;

  logic        clk = 1'b0;
  logic        CLR;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        MemWrite;
  logic        Byte;
  logic        Half;
  logic        UnsignedExt_Mem;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [int unsigned];

  mips_ram #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .CLR             (CLR),
    .addr            (addr),
    .data_in         (data_in),
    .MemWrite        (MemWrite),
    .Byte            (Byte),
    .Half            (Half),
    .UnsignedExt_Mem (UnsignedExt_Mem),
    .data_out        (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int unsigned nbytes(input logic b, input logic h);
    return b ? 1 : (h ? 2 : 4);
  endfunction

  // Significance (in bytes) of the i-th byte counted up from the base address.
  function automatic int unsigned lane(input int unsigned i, input int unsigned n);
`ifdef MIPS_RAM_BIG_ENDIAN_EN
    return n - 1 - i;
`else
    return i;
`endif
  endfunction

  function automatic int unsigned base_of(input logic [31:0] a, input int unsigned n);
    return (a & AMASK) & ~(n - 1);
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    int unsigned n, base;
    logic [31:0] sh;
    n    = nbytes(b, h);
    base = base_of(a, n);
    for (int unsigned i = 0; i < n; i++) begin
      sh = d >> (8 * lane(i, n));
      ref_mem[(base + i) & AMASK] = sh[7:0];
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic b, input logic h,
                                           input logic u);
    int unsigned n, base;
    logic [31:0] v, m;
    n    = nbytes(b, h);
    base = base_of(a, n);
    v    = 32'h0;
    for (int unsigned i = 0; i < n; i++)
      v = v | (32'(ref_rd((base + i) & AMASK)) << (8 * lane(i, n)));
    if (n < 4) begin
      m = (n == 1) ? 32'h0000_00ff : 32'h0000_ffff;
      if (!u && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    @(negedge clk);
    addr = a; data_in = d; Byte = b; Half = h; MemWrite = 1'b1;
    #1 check("store_old", data_out, ref_load(a, b, h, UnsignedExt_Mem));
    @(posedge clk);
    #1 MemWrite = 1'b0;
    ref_store(a, d, b, h);
    #1 check("store_new", data_out, ref_load(a, b, h, UnsignedExt_Mem));
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic b, input logic h,
                         input logic u);
    @(negedge clk);
    addr = a; Byte = b; Half = h; UnsignedExt_Mem = u; MemWrite = 1'b0;
    #1 check(tag, data_out, ref_load(a, b, h, u));
  endtask

  task automatic load_const(input string tag, input logic [31:0] a, input logic b, input logic h,
                            input logic u, input logic [31:0] exp);
    @(negedge clk);
    addr = a; Byte = b; Half = h; UnsignedExt_Mem = u; MemWrite = 1'b0;
    #1 check(tag, data_out, exp);
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic        rb, rh, ru;
    CLR = 1'b1; addr = 32'h0; data_in = 32'h0; MemWrite = 1'b0;
    Byte = 1'b0; Half = 1'b0; UnsignedExt_Mem = 1'b0;
    #1 check("clr_held", data_out, 32'h0);
    #19 CLR = 1'b0;
    ref_mem.delete();

    load_const("reset_lw0", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    load_const("reset_lwtop", AMASK & ~32'h3, 1'b0, 1'b0, 1'b0, 32'h0);
    load_const("reset_lb", 32'h0004_5677, 1'b1, 1'b0, 1'b0, 32'h0);

    do_store(32'h0, 32'h1234_5678, 1'b0, 1'b0);
    do_store(32'h2, 32'h0000_5678, 1'b0, 1'b1);
    load_const("lw0_mixed", 32'h0, 1'b0, 1'b0, 1'b0, 32'h5678_5678);
    load_const("lw_unaligned", 32'h3, 1'b0, 1'b0, 1'b0, 32'h5678_5678);

    do_store(32'h4, 32'h0000_009a, 1'b1, 1'b0);
    do_store(32'h6, 32'h0000_00ef, 1'b0, 1'b1);
    load_const("lw4", 32'h4, 1'b0, 1'b0, 1'b0, 32'h00ef_009a);
    load_const("lb7", 32'h7, 1'b1, 1'b0, 1'b0, 32'h0);
    load_const("lhu6", 32'h6, 1'b0, 1'b1, 1'b1, 32'h0000_00ef);
    load_const("lb4", 32'h4, 1'b1, 1'b0, 1'b0, 32'hffff_ff9a);
    load_const("lbu4", 32'h4, 1'b1, 1'b0, 1'b1, 32'h0000_009a);
    load_const("byte_hal", 32'h4, 1'b1, 1'b1, 1'b1, 32'h0000_009a);

    do_store(32'h4, 32'h0000_8000, 1'b0, 1'b1);
    load_const("lhu4", 32'h4, 1'b0, 1'b1, 1'b1, 32'h0000_8000);
    load_const("lh4", 32'h4, 1'b0, 1'b1, 1'b0, 32'hffff_8000);
    load_const("lh5_unal", 32'h5, 1'b0, 1'b1, 1'b0, 32'hffff_8000);

    do_store(AMASK & ~32'h3, 32'hcafe_f00d, 1'b0, 1'b0);
    load_const("alias_top", 32'hfff0_0000 | (AMASK & ~32'h3), 1'b0, 1'b0, 1'b0, 32'hcafe_f00d);
    do_store(32'h0010_0000, 32'hffff_ff11, 1'b1, 1'b0);
    load_const("alias_zero", 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0011);
    load_const("alias_keep", 32'h1, 1'b1, 1'b0, 1'b1, 32'h0000_0056);

    // CLR arriving mid-cycle while a store is pending.
    @(negedge clk);
    addr = 32'h8; data_in = 32'hdead_beef; Byte = 1'b0; Half = 1'b0; MemWrite = 1'b1;
    #1 CLR = 1'b1;
    #1 check("clr_async", data_out, 32'h0);
    @(posedge clk);
    #1 check("clr_edge", data_out, 32'h0);
    MemWrite = 1'b0;
    #1 CLR = 1'b0;
    ref_mem.delete();
    load_const("clr_nowrite", 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    load_const("clr_lw0", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 400; k++) begin
      ra = ($urandom() & 32'hfff0_0000) |
           (($urandom_range(0, 3) == 0) ? (AMASK - 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 63)));
      rd = $urandom();
      rb = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        UnsignedExt_Mem = ru;
        do_store(ra, rd, rb, rh);
      end else begin
        do_load("rand_load", ra, rb, rh, ru);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
